// File: rtl/key_filter.sv
// Push-button debouncer: 2-flop synchroniser, 4-state filter FSM, registered
// press pulse and debounced level. Optional long-press pulse under `KEY_LONG_PRESS_EN.
module key_filter #(
    parameter int CNT_MAX  = 999_999,
    parameter int CNT_W    = 20,
    parameter int LONG_CNT = 49
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state,
    output logic key_long
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_FILT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_FILT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             key_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_top;
    logic             flag_nxt;
    logic             level_nxt;

    // Synchroniser resets to "released" so reset never fakes a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b1;
            key_s <= 1'b1;
        end else begin
            s1    <= key_in;
            key_s <= s1;
        end
    end

    assign cnt_top = (cnt == CNT_TOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flag_nxt  = 1'b0;
        level_nxt = key_state;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!key_s) begin
                    state_nxt = PRESS_FILT;
                end
            end
            PRESS_FILT: begin
                // A bounce wins even on the final count.
                if (key_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_top) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                    flag_nxt  = 1'b1;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_nxt = RELEASE_FILT;
                    cnt_nxt   = '0;
                end else begin
`ifdef KEY_LONG_PRESS_EN
                    cnt_nxt = cnt_top ? '0 : cnt + CNT_W'(1);
`else
                    cnt_nxt = '0;
`endif
                end
            end
            RELEASE_FILT: begin
                if (!key_s) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                end else if (cnt_top) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            key_flag  <= 1'b0;
            key_state <= 1'b1;
        end else begin
            cnt       <= cnt_nxt;
            key_flag  <= flag_nxt;
            key_state <= level_nxt;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam logic [5:0] LCNT_HIT = 6'(LONG_CNT);
    localparam logic [5:0] LCNT_SAT = 6'(LONG_CNT + 1);

    // Counts wraps up to one past the threshold, then holds so the pulse cannot repeat.
    function automatic logic [5:0] lcnt_sat_inc(input logic [5:0] v);
        if (v < LCNT_SAT) begin
            return v + 6'd1;
        end
        return v;
    endfunction

    logic [5:0] lcnt;
    logic       wrap;
    logic       press_entry;

    assign wrap        = (state == DOWN) && !key_s && cnt_top;
    assign press_entry = (state == PRESS_FILT) && (state_nxt == DOWN);

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt     <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= wrap && (lcnt == LCNT_HIT);
            if (press_entry) begin
                lcnt <= '0;
            end else if (wrap) begin
                lcnt <= lcnt_sat_inc(lcnt);
            end
        end
    end
`else
    // Feature absent: constant low, with LONG_CNT kept referenced in this build too.
    assign key_long = 1'b0 & (LONG_CNT != 0);
`endif

endmodule

// File: tb/tb_key_filter.sv
// Randomised + directed bench for key_filter with a run-length reference model and
// a per-cycle scoreboard queue.
module tb_key_filter;

    localparam int CNT_MAX  = 9;
    localparam int CNT_W    = 4;
    localparam int LONG_CNT = 3;

    logic clk;
    logic rst;
    logic key_in;
    logic key_flag;
    logic key_state;
    logic key_long;

    key_filter #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W),
        .LONG_CNT(LONG_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_flag (key_flag),
        .key_state(key_state),
        .key_long (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic flag;
        logic state;
        logic long_p;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: the debounced level flips after CNT_MAX+2 consecutive
    // synchronised samples disagreeing with it; the sampled pin reaches the
    // filter two edges late. Long press: every CNT_MAX+1 undisturbed held
    // samples is one period; the (LONG_CNT+1)-th period after a press pulses once.
    int   hist1 = 1, hist2 = 1;
    int   lvl = 1, run = 0, dr = 0, periods = 0;
    always @(posedge clk) begin
        exp_t e;
        int   obs;
        cyc++;
        e.flag   = 1'b0;
        e.long_p = 1'b0;
        if (rst) begin
            hist1 = 1; hist2 = 1; lvl = 1; run = 0; dr = 0; periods = 0;
        end else begin
            obs   = hist2;
            hist2 = hist1;
            hist1 = int'(key_in);
            if (obs != lvl) begin
                run++;
                dr = 0;
                if (run == CNT_MAX + 2) begin
                    lvl = obs;
                    run = 0;
                    if (lvl == 0) begin
                        e.flag  = 1'b1;
                        periods = 0;
                    end
                end
            end else begin
                if (lvl == 0) begin
                    if (run > 0) begin
                        dr = 0;
                    end else begin
                        dr++;
                        if (dr == CNT_MAX + 1) begin
                            dr = 0;
                            periods++;
`ifdef KEY_LONG_PRESS_EN
                            if (periods == LONG_CNT + 1) e.long_p = 1'b1;
`endif
                        end
                    end
                end
                run = 0;
            end
        end
        e.state = logic'(lvl);
        exp_q.push_back(e);
    end

    // Monitor: compares every registered output cycle against the model.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (key_flag === e.flag && key_state === e.state && key_long === e.long_p) begin
                n_pass++;
            end else begin
                $display("FAIL outputs cyc=%0d got flag=%b state=%b long=%b expected flag=%b state=%b long=%b",
                         cyc, key_flag, key_state, key_long, e.flag, e.state, e.long_p);
            end
        end
    end

    // Pulse counters for directed scenario checks.
    int flag_cnt = 0;
    int long_cnt_seen = 0;
    always @(negedge clk) begin
        if (key_flag === 1'b1) flag_cnt++;
        if (key_long === 1'b1) long_cnt_seen++;
    end

    task automatic hold(input int n, input logic k);
        repeat (n) begin
            key_in = k;
            @(negedge clk);
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, want);
    endtask

    initial begin
        int f0;
        int l0;
        rst    = 1'b1;
        key_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(50, 1'b1);
        check_count("idle_no_flag", flag_cnt, 0);

        f0 = flag_cnt;
        hold(40, 1'b0);
        check_count("single_press_flag", flag_cnt - f0, 1);
        hold(20, 1'b1);

        f0 = flag_cnt;
        for (int i = 0; i < 10; i++) hold(4, (i % 2 == 0) ? 1'b0 : 1'b1);
        hold(20, 1'b1);
        check_count("chatter_no_flag", flag_cnt - f0, 0);

        f0 = flag_cnt;
        hold(20, 1'b0);
        hold(3, 1'b1);
        hold(5, 1'b0);
        hold(20, 1'b1);
        check_count("release_bounce_one_flag", flag_cnt - f0, 1);

        f0 = flag_cnt;
        hold(7, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(30, 1'b0);
        check_count("reset_refilter_flag", flag_cnt - f0, 1);
        hold(20, 1'b1);

        l0 = long_cnt_seen;
        hold(130, 1'b0);
`ifdef KEY_LONG_PRESS_EN
        check_count("long_press_once", long_cnt_seen - l0, 1);
`else
        check_count("long_press_absent", long_cnt_seen - l0, 0);
`endif
        hold(20, 1'b1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            hold(int'($urandom_range(1, 25)), logic'($urandom_range(0, 1)));
        end
        hold(30, 1'b1);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
